vga_pixel_probe: RTL and testbench

- Read-back stage on the VGA pixel stream, inserted after the background and sprite drawing stages.
- Gameplay logic issues a coordinate query. The block waits for that pixel to pass in the next full frame, captures its RGB value and reports whether the pixel is a wall.
- Gives game logic collision information from the same stream that draws the maze. The stream passes through with one register of delay.

---
 rtl/vga_pixel_probe_if.sv | 20 ++
 rtl/vga_pixel_probe.sv | 155 +++++++++++++++
 tb/tb_vga_pixel_probe.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_probe_if.sv
// vga_if: one VGA pixel-stream sample.
//   hcount/vcount : current pixel column/row (11 bit, unsigned)
//   hsync/vsync   : sync strobes
//   hblnk/vblnk   : blanking flags, high outside the visible area
//   rgb           : 4:4:4 pixel colour
// Modports:
//   in  : the consumer's view (all fields are inputs)
//   out : the producer's view (all fields are outputs)
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_pixel_probe.sv
// vga_pixel_probe: read-back tap on the VGA pixel stream.
// Game logic asks for one (x, y) coordinate. The block waits for the next
// full frame, captures the colour of that pixel as it goes past, and reports
// whether the pixel is drawn in the wall colour. The stream is forwarded
// with one register of delay whatever the query state is.
//
// Ports:
//   clk, rst     pixel clock, synchronous active-high reset
//   vga_in       incoming pixel stream (vga_if.in)
//   vga_out      the same stream delayed by one clock (vga_if.out)
//   req_*        query channel: req_valid/req_ready, req_x, req_y
//   resp_*       result channel: resp_valid/resp_ready, resp_rgb,
//                resp_wall, resp_err
//   dbg_state    current FSM state (IDLE=0, WAIT_SOF=1, SEARCH=2, RESP=3)
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high at the rising clock edge. The producer holds valid and its payload
// until that edge; ready carries no promise about later cycles.
module vga_pixel_probe #(
   parameter int unsigned HOR_PIXELS = 1024,
   parameter int unsigned VER_PIXELS = 768,
   parameter logic [11:0] WALL_RGB   = 12'h00F
) (
   input  logic        clk,
   input  logic        rst,
   vga_if.in           vga_in,
   vga_if.out          vga_out,
   input  logic        req_valid,
   input  logic [10:0] req_x,
   input  logic [10:0] req_y,
   output logic        req_ready,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [11:0] resp_rgb,
   output logic        resp_wall,
   output logic        resp_err,
   output logic [1:0]  dbg_state
);

   localparam logic [10:0] HOR_LIM = HOR_PIXELS[10:0];
   localparam logic [10:0] VER_LIM = VER_PIXELS[10:0];

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      SEARCH   = 2'd2,
      RESP     = 2'd3
   } state_t;

   state_t      state;
   logic [10:0] x_q;
   logic [10:0] y_q;
   logic        sof;
   logic        match;

   assign sof   = (vga_in.hcount == 11'd0) && (vga_in.vcount == 11'd0);
   assign match = (vga_in.hcount == x_q) && (vga_in.vcount == y_q) &&
                  !vga_in.hblnk && !vga_in.vblnk;

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         vga_out.hcount <= 11'd0;
         vga_out.vcount <= 11'd0;
         vga_out.hsync  <= 1'b0;
         vga_out.vsync  <= 1'b0;
         vga_out.hblnk  <= 1'b0;
         vga_out.vblnk  <= 1'b0;
         vga_out.rgb    <= 12'd0;
         state          <= IDLE;
         x_q            <= 11'd0;
         y_q            <= 11'd0;
         req_ready      <= 1'b0;
         resp_valid     <= 1'b0;
         resp_rgb       <= 12'd0;
         resp_wall      <= 1'b0;
         resp_err       <= 1'b0;
      end else begin
         vga_out.hcount <= vga_in.hcount;
         vga_out.vcount <= vga_in.vcount;
         vga_out.hsync  <= vga_in.hsync;
         vga_out.vsync  <= vga_in.vsync;
         vga_out.hblnk  <= vga_in.hblnk;
         vga_out.vblnk  <= vga_in.vblnk;
         vga_out.rgb    <= vga_in.rgb;

         case (state)
            IDLE: begin
               // req_ready rises one cycle after entering IDLE, so a query
               // is never accepted in the cycle the previous one retires.
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  x_q       <= req_x;
                  y_q       <= req_y;
                  if ((req_x >= HOR_LIM) || (req_y >= VER_LIM)) begin
                     // Can never be drawn: answer at once, no frame wait.
                     resp_rgb   <= 12'd0;
                     resp_wall  <= 1'b0;
                     resp_err   <= 1'b1;
                     resp_valid <= 1'b1;
                     state      <= RESP;
                  end else begin
                     state <= WAIT_SOF;
                  end
               end
            end

            WAIT_SOF: begin
               if (sof) begin
                  // The SOF pixel is itself (0,0), so it can be the answer.
                  if (match) begin
                     resp_rgb   <= vga_in.rgb;
                     resp_wall  <= (vga_in.rgb == WALL_RGB);
                     resp_err   <= 1'b0;
                     resp_valid <= 1'b1;
                     state      <= RESP;
                  end else begin
                     state <= SEARCH;
                  end
               end
            end

            SEARCH: begin
               // A match wins over the SOF that would close the search.
               if (match) begin
                  resp_rgb   <= vga_in.rgb;
                  resp_wall  <= (vga_in.rgb == WALL_RGB);
                  resp_err   <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else if (sof) begin
                  // A whole frame went by without the pixel being visible.
                  resp_rgb   <= 12'd0;
                  resp_wall  <= 1'b0;
                  resp_err   <= 1'b1;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end
            end

            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_pixel_probe.sv
// tb_vga_pixel_probe: directed sequence with randomised pixel streams.
// Each query gets a freshly built stream (a few blanked filler samples, then
// frames that start with an SOF sample). The expected answer is found by
// scanning that stream: first SOF after acceptance, then the first visible
// sample at the query coordinate before the following SOF.
module tb_vga_pixel_probe;

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
   } pix_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [10:0] req_x = 11'd0;
   logic [10:0] req_y = 11'd0;
   logic        req_ready;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [11:0] resp_rgb;
   logic        resp_wall;
   logic        resp_err;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   pix_t stream[$];
   int   ptr = 0;

   always #5 clk = ~clk;

   vga_if vin();
   vga_if vout();

   vga_pixel_probe dut (
      .clk        (clk),
      .rst        (rst),
      .vga_in     (vin),
      .vga_out    (vout),
      .req_valid  (req_valid),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rgb   (resp_rgb),
      .resp_wall  (resp_wall),
      .resp_err   (resp_err),
      .dbg_state  (dbg_state)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] non_wall();
      logic [11:0] c;
      c = 12'($urandom);
      if (c == 12'h00F) c = 12'h0F0;
      return c;
   endfunction

   function automatic pix_t rnd_pix();
      pix_t p;
      p.h   = 11'($urandom_range(1, 1343));
      p.v   = 11'($urandom_range(0, 767));
      p.hs  = 1'($urandom);
      p.vs  = 1'($urandom);
      p.hb  = (p.h >= 11'd1024) || ($urandom_range(0, 7) == 0);
      p.vb  = 1'b0;
      p.rgb = non_wall();
      return p;
   endfunction

   function automatic pix_t filler_pix();
      pix_t p;
      p.h   = 11'($urandom_range(1100, 1343));
      p.v   = 11'($urandom_range(0, 805));
      p.hs  = 1'($urandom);
      p.vs  = 1'($urandom);
      p.hb  = 1'b1;
      p.vb  = 1'b1;
      p.rgb = 12'd0;
      return p;
   endfunction

   function automatic logic is_sof(input pix_t p);
      return (p.h == 11'd0) && (p.v == 11'd0);
   endfunction

   function automatic logic is_hit(input pix_t p, input logic [10:0] x, input logic [10:0] y);
      return (p.h == x) && (p.v == y) && !p.hb && !p.vb;
   endfunction

   task automatic new_stream();
      stream.delete();
      ptr = 0;
      for (int i = 0; i < 3; i++) stream.push_back(filler_pix());
   endtask

   // One frame: SOF sample, then n samples; optionally one of them is the
   // target coordinate with the given colour and hblnk value.
   task automatic add_frame(input int n, input logic [10:0] tx, input logic [10:0] ty,
                            input logic [11:0] trgb, input logic thb, input logic put);
      pix_t p;
      int   k;
      p = rnd_pix();
      p.h = 11'd0;
      p.v = 11'd0;
      p.hb = 1'b0;
      if (put && tx == 11'd0 && ty == 11'd0) begin
         p.rgb = trgb;
         p.hb  = thb;
      end
      stream.push_back(p);
      k = $urandom_range(0, n - 1);
      for (int i = 0; i < n; i++) begin
         p = rnd_pix();
         if (put && i == k && !(tx == 11'd0 && ty == 11'd0)) begin
            p.h   = tx;
            p.v   = ty;
            p.hb  = thb;
            p.rgb = trgb;
         end
         stream.push_back(p);
      end
   endtask

   // Reference: which edge (stream index) produces the response, and with what.
   function automatic void model(input int acc, input logic [10:0] x, input logic [10:0] y,
                                 output int ev, output logic [11:0] rgb, output logic err);
      int s;
      s   = -1;
      ev  = -1;
      rgb = 12'd0;
      err = 1'b1;
      if (x >= 11'd1024 || y >= 11'd768) begin
         ev = acc;
         return;
      end
      for (int i = acc + 1; i < stream.size(); i++) begin
         if (is_sof(stream[i])) begin
            s = i;
            break;
         end
      end
      if (s < 0) return;
      for (int i = s; i < stream.size(); i++) begin
         if (is_hit(stream[i], x, y)) begin
            ev  = i;
            rgb = stream[i].rgb;
            err = 1'b0;
            return;
         end
         if (i > s && is_sof(stream[i])) begin
            ev = i;
            return;
         end
      end
   endfunction

   // Drive the next stream sample, take one clock edge, check pass-through.
   task automatic cycle();
      pix_t cur;
      pix_t obs;
      logic was_rst;
      cur = (ptr < stream.size()) ? stream[ptr] : filler_pix();
      vin.hcount = cur.h;
      vin.vcount = cur.v;
      vin.hsync  = cur.hs;
      vin.vsync  = cur.vs;
      vin.hblnk  = cur.hb;
      vin.vblnk  = cur.vb;
      vin.rgb    = cur.rgb;
      @(posedge clk);
      was_rst = rst;
      ptr++;
      #1;
      obs = {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
      check("pass_through", obs, was_rst ? 38'd0 : cur);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
         cycle();
         n++;
      end
      check("req_ready_wait", {63'd0, req_ready}, 64'd1);
   endtask

   task automatic do_query(input logic [10:0] x, input logic [10:0] y, input int hold,
                           input string tag);
      int          acc;
      int          exp_ev;
      int          got_ev;
      int          n;
      logic [11:0] exp_rgb;
      logic        exp_err;
      logic        exp_wall;
      acc = ptr;
      req_valid = 1'b1;
      req_x = x;
      req_y = y;
      cycle();
      req_valid = 1'b0;
      req_x = 11'($urandom);
      req_y = 11'($urandom);
      model(acc, x, y, exp_ev, exp_rgb, exp_err);
      exp_wall = (exp_rgb == 12'h00F) && !exp_err;
      n = 0;
      while (resp_valid !== 1'b1 && n < 400) begin
         cycle();
         n++;
      end
      got_ev = (resp_valid === 1'b1) ? ptr - 1 : -1;
      check({tag, "_latency"}, 64'(got_ev), 64'(exp_ev));
      check({tag, "_rgb"},  {52'd0, resp_rgb},  {52'd0, exp_rgb});
      check({tag, "_wall"}, {63'd0, resp_wall}, {63'd0, exp_wall});
      check({tag, "_err"},  {63'd0, resp_err},  {63'd0, exp_err});
      for (int i = 0; i < hold; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            req_valid = 1'b1;
            req_x = 11'($urandom_range(0, 1023));
            req_y = 11'($urandom_range(0, 767));
         end
         cycle();
         req_valid = 1'b0;
         check({tag, "_hold_valid"}, {63'd0, resp_valid}, 64'd1);
         check({tag, "_hold_ready"}, {63'd0, req_ready}, 64'd0);
         check({tag, "_hold_data"}, {50'd0, resp_rgb, resp_wall, resp_err},
               {50'd0, exp_rgb, exp_wall, exp_err});
      end
      resp_ready = 1'b1;
      cycle();
      resp_ready = 1'b0;
      check({tag, "_drop_valid"}, {63'd0, resp_valid}, 64'd0);
      check({tag, "_drop_ready"}, {63'd0, req_ready}, 64'd0);
      check({tag, "_persist"}, {50'd0, resp_rgb, resp_wall, resp_err},
            {50'd0, exp_rgb, exp_wall, exp_err});
      cycle();
      check({tag, "_ready_back"}, {63'd0, req_ready}, 64'd1);
   endtask

   initial begin
      int seen;

      // Reset state
      new_stream();
      rst = 1'b1;
      repeat (3) cycle();
      check("rst_req_ready", {63'd0, req_ready}, 64'd0);
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("rst_resp_data", {50'd0, resp_rgb, resp_wall, resp_err}, 64'd0);
      rst = 1'b0;
      cycle();
      check("rst_ready_up", {63'd0, req_ready}, 64'd1);

      // Wall hit at (5,200)
      wait_ready();
      new_stream();
      add_frame(40, 11'd5, 11'd200, 12'h00F, 1'b0, 1'b1);
      add_frame(20, 11'd5, 11'd200, 12'h123, 1'b0, 1'b1);
      do_query(11'd5, 11'd200, 2, "wall_hit");

      // Non-wall pixel at (512,384)
      wait_ready();
      new_stream();
      add_frame(40, 11'd512, 11'd384, 12'h0FF, 1'b0, 1'b1);
      add_frame(20, 11'd512, 11'd384, 12'h00F, 1'b0, 1'b1);
      do_query(11'd512, 11'd384, 1, "non_wall");

      // Out of range in x, then in y
      wait_ready();
      new_stream();
      add_frame(20, 11'd0, 11'd10, 12'h00F, 1'b0, 1'b0);
      do_query(11'd1024, 11'd10, 0, "oor_x");
      wait_ready();
      new_stream();
      add_frame(20, 11'd10, 11'd0, 12'h00F, 1'b0, 1'b0);
      do_query(11'd10, 11'd768, 0, "oor_y");

      // Target blanked for a whole frame: error at the second SOF
      wait_ready();
      new_stream();
      add_frame(30, 11'd100, 11'd100, 12'h00F, 1'b1, 1'b1);
      add_frame(30, 11'd100, 11'd100, 12'h00F, 1'b0, 1'b1);
      do_query(11'd100, 11'd100, 0, "blanked");

      // Backpressure over three more frames, target recoloured in each
      wait_ready();
      new_stream();
      add_frame(25, 11'd40, 11'd60, 12'h00F, 1'b0, 1'b1);
      add_frame(25, 11'd40, 11'd60, 12'h456, 1'b0, 1'b1);
      add_frame(25, 11'd40, 11'd60, 12'h789, 1'b0, 1'b1);
      add_frame(25, 11'd40, 11'd60, 12'hABC, 1'b0, 1'b1);
      do_query(11'd40, 11'd60, 90, "backpressure");

      // Reset while searching: no response for the aborted query
      wait_ready();
      new_stream();
      add_frame(30, 11'd300, 11'd300, 12'h00F, 1'b0, 1'b1);
      add_frame(30, 11'd300, 11'd300, 12'h00F, 1'b0, 1'b1);
      req_valid = 1'b1;
      req_x = 11'd300;
      req_y = 11'd300;
      cycle();
      req_valid = 1'b0;
      while (ptr < 4) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("midrst_req_ready", {63'd0, req_ready}, 64'd0);
      check("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("midrst_resp_data", {50'd0, resp_rgb, resp_wall, resp_err}, 64'd0);
      seen = 0;
      for (int i = 0; i < 75; i++) begin
         cycle();
         if (resp_valid === 1'b1) seen++;
      end
      check("midrst_no_resp", 64'(seen), 64'd0);
      check("midrst_ready", {63'd0, req_ready}, 64'd1);

      // Randomised queries
      for (int q = 0; q < 12; q++) begin
         logic [10:0] x;
         logic [10:0] y;
         int          kind;
         kind = $urandom_range(0, 5);
         x = 11'($urandom_range(0, 1023));
         y = 11'($urandom_range(0, 767));
         if (kind == 0) x = 11'($urandom_range(1024, 2047));
         else if (kind == 1) y = 11'($urandom_range(768, 2047));
         else if (kind == 2) begin
            x = 11'd0;
            y = 11'd0;
         end
         wait_ready();
         new_stream();
         add_frame(20, x, y, ($urandom_range(0, 1) != 0) ? 12'h00F : non_wall(),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
         add_frame(20, x, y, ($urandom_range(0, 1) != 0) ? 12'h00F : non_wall(),
                   1'b0, ($urandom_range(0, 1) != 0));
         do_query(x, y, $urandom_range(0, 5), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
